// File: rtl/stream_rr_arbiter_if.sv
// stream_rr_arbiter_if
//   Bundles the N-input FWFT read side and the single write side of the
//   round-robin stream arbiter.
//
//   Parameters: NUM_IN (input streams), DATA_WIDTH (payload bits per word).
//   Signals:
//     in_empty_n [NUM_IN]             per-input "head word valid" (FWFT)
//     in_read    [NUM_IN]             per-input pop strobe (arbiter drives)
//     in_dout    [NUM_IN*DATA_WIDTH]  head words, input i at [i*DATA_WIDTH +: DATA_WIDTH]
//     out_full_n                      downstream not-almost-full
//     out_write                       registered write strobe (arbiter drives)
//     out_din    [OUT_W]              registered output word (arbiter drives)
//   Macro STREAM_RR_ARBITER_TAG_EN widens out_din by the source index width.
//   Modports: master = arbiter side, slave = sources/sink side.
interface stream_rr_arbiter_if #(
  parameter int NUM_IN     = 4,
  parameter int DATA_WIDTH = 32
);
  localparam int IDX_W = $clog2(NUM_IN);
`ifdef STREAM_RR_ARBITER_TAG_EN
  localparam int OUT_W = DATA_WIDTH + IDX_W;
`else
  localparam int OUT_W = DATA_WIDTH;
`endif

  logic [NUM_IN-1:0]            in_empty_n;
  logic [NUM_IN-1:0]            in_read;
  logic [NUM_IN*DATA_WIDTH-1:0] in_dout;
  logic                         out_full_n;
  logic                         out_write;
  logic [OUT_W-1:0]             out_din;

  modport master (
    input  in_empty_n, in_dout, out_full_n,
    output in_read, out_write, out_din
  );

  modport slave (
    output in_empty_n, in_dout, out_full_n,
    input  in_read, out_write, out_din
  );
endinterface

// File: rtl/stream_rr_arbiter.sv
// stream_rr_arbiter
//   Round-robin merge of NUM_IN FWFT input streams into one write stream.
//   An input holds the grant for up to MAX_BURST consecutive words; the grant
//   is released when the input runs dry, the downstream goes not-ready, or
//   the burst limit is reached. Each release costs one bubble cycle, after
//   which arbitration restarts from the input following the released one.
//
//   Ports:
//     clk    rising-edge clock
//     reset  synchronous, active-high; also masks in_read combinationally
//     bus    stream_rr_arbiter_if.master (in_empty_n/in_read/in_dout,
//            out_full_n/out_write/out_din)
//
//   Parameters: NUM_IN (2..16), DATA_WIDTH, MAX_BURST (1..255).
//   Optional feature: define STREAM_RR_ARBITER_TAG_EN to append the source
//   index above the data in out_din (out_din[DATA_WIDTH +: IDX_W]).
module stream_rr_arbiter #(
  parameter int NUM_IN     = 4,
  parameter int DATA_WIDTH = 32,
  parameter int MAX_BURST  = 8
) (
  input  logic                clk,
  input  logic                reset,
  stream_rr_arbiter_if.master bus
);
  localparam int IDX_W = $clog2(NUM_IN);

  typedef enum logic {
    IDLE = 1'b0,
    HOLD = 1'b1
  } state_t;

  state_t           state, state_nxt;
  logic [IDX_W-1:0] grant, grant_nxt;
  logic [IDX_W-1:0] rr_ptr, rr_ptr_nxt;
  logic [7:0]       burst_cnt, burst_cnt_nxt;

  logic [IDX_W-1:0]      sel;
  logic                  sel_vld;
  logic                  hold_go;
  logic                  rd_go;
  logic [IDX_W-1:0]      rd_idx;
  logic [DATA_WIDTH-1:0] rd_word;

  // (base + off) mod NUM_IN for base, off < NUM_IN. One extra bit covers the
  // sum, so a single conditional subtract is enough even for non-power-of-two
  // NUM_IN.
  function automatic logic [IDX_W-1:0] wrap_add(input logic [IDX_W-1:0] base,
                                                input int off);
    logic [IDX_W:0] s;
    s = {1'b0, base} + (IDX_W+1)'(off);
    if (s >= (IDX_W+1)'(NUM_IN)) s = s - (IDX_W+1)'(NUM_IN);
    return s[IDX_W-1:0];
  endfunction

  // First valid input at or after rr_ptr, circularly. Scanning offsets from
  // high to low lets the smallest offset land last and win.
  always_comb begin
    sel     = '0;
    sel_vld = 1'b0;
    for (int k = NUM_IN - 1; k >= 0; k--) begin
      if (bus.in_empty_n[wrap_add(rr_ptr, k)]) begin
        sel     = wrap_add(rr_ptr, k);
        sel_vld = 1'b1;
      end
    end
  end

  // Keep the burst going only while the owner has data, the sink has room
  // and the burst budget is not spent.
  assign hold_go = bus.out_full_n && bus.in_empty_n[grant] &&
                   (burst_cnt < 8'(MAX_BURST));

  always_comb begin
    state_nxt     = state;
    grant_nxt     = grant;
    rr_ptr_nxt    = rr_ptr;
    burst_cnt_nxt = burst_cnt;
    rd_go         = 1'b0;
    rd_idx        = grant;
    case (state)
      IDLE: begin
        if (bus.out_full_n && sel_vld) begin
          rd_go         = 1'b1;
          rd_idx        = sel;
          grant_nxt     = sel;
          burst_cnt_nxt = 8'd1;
          state_nxt     = HOLD;
        end
      end
      HOLD: begin
        if (hold_go) begin
          rd_go         = 1'b1;
          burst_cnt_nxt = burst_cnt + 8'd1;
        end else begin
          // Release: this cycle is the bubble, next IDLE cycle re-arbitrates
          // starting just past the old owner.
          rr_ptr_nxt = wrap_add(grant, 1);
          state_nxt  = IDLE;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Pop strobes: one-hot on rd_idx, masked by reset without waiting a clock.
  for (genvar i = 0; i < NUM_IN; i++) begin : g_rd
    assign bus.in_read[i] = rd_go && !reset && (rd_idx == IDX_W'(i));
  end

  assign rd_word = bus.in_dout[rd_idx*DATA_WIDTH +: DATA_WIDTH];

  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= IDLE;
      grant     <= '0;
      rr_ptr    <= '0;
      burst_cnt <= '0;
    end else begin
      state     <= state_nxt;
      grant     <= grant_nxt;
      rr_ptr    <= rr_ptr_nxt;
      burst_cnt <= burst_cnt_nxt;
    end
  end

  // Output register: one cycle behind the pop; the word is held between pops.
  always_ff @(posedge clk) begin
    if (reset) begin
      bus.out_write <= 1'b0;
      bus.out_din   <= '0;
    end else begin
      bus.out_write <= rd_go;
      if (rd_go) begin
`ifdef STREAM_RR_ARBITER_TAG_EN
        bus.out_din <= {rd_idx, rd_word};
`else
        bus.out_din <= rd_word;
`endif
      end
    end
  end
endmodule

// File: tb/tb_stream_rr_arbiter.sv
// tb_stream_rr_arbiter
//   Three arbiter instances (4 in/burst 8, 4 in/burst 3, 3 in/burst 1) fed
//   from queue-backed FWFT sources. A transaction-level model of the
//   grant rules predicts every pop and every registered output word.
module tb_stream_rr_arbiter;
  localparam int DW = 32;
`ifdef STREAM_RR_ARBITER_TAG_EN
  localparam int OW = DW + 2;
`else
  localparam int OW = DW;
`endif
  localparam int NU = 3;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  // driven copies (updated only at the falling edge)
  logic          rst;
  logic          f_drv [NU];
  logic [15:0]   vld   [NU];
  logic [DW-1:0] head  [NU][16];

  // scenario-side requests
  logic rst_req;
  logic full_req [NU];
  logic gate     [NU][16];

  logic [15:0]   rd_obs  [NU];
  logic          wr_obs  [NU];
  logic [OW-1:0] din_obs [NU];

  stream_rr_arbiter_if #(.NUM_IN(4), .DATA_WIDTH(DW)) ifc0 ();
  stream_rr_arbiter_if #(.NUM_IN(4), .DATA_WIDTH(DW)) ifc1 ();
  stream_rr_arbiter_if #(.NUM_IN(3), .DATA_WIDTH(DW)) ifc2 ();

  stream_rr_arbiter #(.NUM_IN(4), .DATA_WIDTH(DW), .MAX_BURST(8)) dut0 (
    .clk(clk), .reset(rst), .bus(ifc0.master));
  stream_rr_arbiter #(.NUM_IN(4), .DATA_WIDTH(DW), .MAX_BURST(3)) dut1 (
    .clk(clk), .reset(rst), .bus(ifc1.master));
  stream_rr_arbiter #(.NUM_IN(3), .DATA_WIDTH(DW), .MAX_BURST(1)) dut2 (
    .clk(clk), .reset(rst), .bus(ifc2.master));

  assign ifc0.in_empty_n = vld[0][3:0];
  assign ifc1.in_empty_n = vld[1][3:0];
  assign ifc2.in_empty_n = vld[2][2:0];
  assign ifc0.in_dout    = {head[0][3], head[0][2], head[0][1], head[0][0]};
  assign ifc1.in_dout    = {head[1][3], head[1][2], head[1][1], head[1][0]};
  assign ifc2.in_dout    = {head[2][2], head[2][1], head[2][0]};
  assign ifc0.out_full_n = f_drv[0];
  assign ifc1.out_full_n = f_drv[1];
  assign ifc2.out_full_n = f_drv[2];

  assign rd_obs[0]  = 16'(ifc0.in_read);
  assign rd_obs[1]  = 16'(ifc1.in_read);
  assign rd_obs[2]  = 16'(ifc2.in_read);
  assign wr_obs[0]  = ifc0.out_write;
  assign wr_obs[1]  = ifc1.out_write;
  assign wr_obs[2]  = ifc2.out_write;
  assign din_obs[0] = ifc0.out_din;
  assign din_obs[1] = ifc1.out_din;
  assign din_obs[2] = ifc2.out_din;

  int nin [NU] = '{4, 4, 3};
  int mb  [NU] = '{8, 3, 1};

  // source FIFOs and model state
  logic [DW-1:0] fifo [NU][16][$];
  int            owner [NU];   // -1: no grant held
  int            cnt   [NU];
  int            ptr   [NU];
  bit            known [NU];
  logic          ewr   [NU];
  logic [OW-1:0] edin  [NU];

  int obs_src [NU][$];
  int obs_cyc [NU][$];
  int cyc;

  int n_cmp = 0;
  int n_err = 0;

  task automatic chk(input string tag, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h want %0h", tag, act, exp);
    end
  endtask

  // One clock: drive at the falling edge, check, then advance the model.
  task automatic step();
    int rd [NU];
    @(negedge clk);
    cyc++;
    rst = rst_req;
    for (int u = 0; u < NU; u++) begin
      f_drv[u] = full_req[u];
      for (int i = 0; i < 16; i++) begin
        vld[u][i]  = (i < nin[u]) && (fifo[u][i].size() > 0) && gate[u][i];
        head[u][i] = (fifo[u][i].size() > 0) ? fifo[u][i][0] : '0;
      end
    end
    #1;
    for (int u = 0; u < NU; u++) begin
      rd[u] = -1;
      if (!rst) begin
        if (owner[u] < 0) begin
          if (f_drv[u] && vld[u] != 16'd0)
            for (int k = nin[u] - 1; k >= 0; k--)
              if (vld[u][(ptr[u] + k) % nin[u]]) rd[u] = (ptr[u] + k) % nin[u];
        end else if (f_drv[u] && vld[u][owner[u]] && cnt[u] < mb[u]) begin
          rd[u] = owner[u];
        end
      end
      chk($sformatf("u%0d_in_read", u), 64'(rd_obs[u]),
          (rd[u] >= 0) ? (64'd1 << rd[u]) : 64'd0);
      if (known[u]) begin
        chk($sformatf("u%0d_out_write", u), 64'(wr_obs[u]), 64'(ewr[u]));
        chk($sformatf("u%0d_out_din", u), 64'(din_obs[u]), 64'(edin[u]));
      end
      for (int i = 0; i < 16; i++)
        if (rd_obs[u][i]) begin
          obs_src[u].push_back(i);
          obs_cyc[u].push_back(cyc);
        end
      if (rst) begin
        owner[u] = -1; ptr[u] = 0; cnt[u] = 0;
        ewr[u] = 1'b0; edin[u] = '0; known[u] = 1'b1;
      end else if (rd[u] >= 0) begin
        ewr[u] = 1'b1;
`ifdef STREAM_RR_ARBITER_TAG_EN
        edin[u] = {2'(rd[u]), head[u][rd[u]]};
`else
        edin[u] = head[u][rd[u]];
`endif
        void'(fifo[u][rd[u]].pop_front());
        if (owner[u] < 0) begin owner[u] = rd[u]; cnt[u] = 1; end
        else cnt[u]++;
      end else begin
        ewr[u] = 1'b0;
        if (owner[u] >= 0) begin
          ptr[u]   = (owner[u] + 1) % nin[u];
          owner[u] = -1;
        end
      end
    end
  endtask

  function automatic int pending();
    int n = 0;
    for (int u = 0; u < NU; u++) begin
      for (int i = 0; i < 16; i++) n += fifo[u][i].size();
      if (owner[u] >= 0) n++;
    end
    return n;
  endfunction

  task automatic open_all();
    for (int u = 0; u < NU; u++) begin
      full_req[u] = 1'b1;
      for (int i = 0; i < 16; i++) gate[u][i] = 1'b1;
    end
  endtask

  task automatic drain(input int budget);
    int left = budget;
    open_all();
    while (left > 0 && pending() > 0) begin step(); left--; end
    repeat (2) step();
    chk("drain_left", 64'(pending()), 64'd0);
  endtask

  task automatic do_reset(input int n);
    rst_req = 1'b1;
    repeat (n) step();
    rst_req = 1'b0;
    for (int u = 0; u < NU; u++) begin
      obs_src[u].delete();
      obs_cyc[u].delete();
    end
  endtask

  task automatic push(input int u, input int i, input int n);
    for (int j = 0; j < n; j++) fifo[u][i].push_back($urandom);
  endtask

  task automatic cmp_seq(input string tag, input int u, input int exp[$]);
    chk({tag, "_n"}, 64'(obs_src[u].size()), 64'(exp.size()));
    for (int j = 0; j < exp.size() && j < obs_src[u].size(); j++)
      chk($sformatf("%s_src%0d", tag, j), 64'(obs_src[u][j]), 64'(exp[j]));
  endtask

  initial begin
    int exp_seq[$];
    int r [3];
    int cur, wcnt;
    logic [OW-1:0] tag_exp;

    cyc = 0;
    rst = 1'b1; rst_req = 1'b1;
    for (int u = 0; u < NU; u++) begin
      f_drv[u] = 1'b1; vld[u] = '0; owner[u] = -1; cnt[u] = 0; ptr[u] = 0;
      known[u] = 1'b0; ewr[u] = 1'b0; edin[u] = '0;
      for (int i = 0; i < 16; i++) head[u][i] = '0;
    end
    open_all();

    // reset held with every input valid: no pops, outputs at zero
    for (int u = 0; u < NU; u++) for (int i = 0; i < nin[u]; i++) push(u, i, 1);
    do_reset(3);
    rst_req = 1'b1;
    for (int u = 0; u < NU; u++) for (int i = 0; i < 16; i++) fifo[u][i].delete();
    do_reset(1);

    // two words per input, ordered round robin with one bubble per source
    for (int i = 0; i < 4; i++) push(0, i, 2);
    drain(100);
    exp_seq = '{0, 0, 1, 1, 2, 2, 3, 3};
    cmp_seq("rr2", 0, exp_seq);
    for (int j = 0; j + 1 < obs_cyc[0].size() && j < 7; j++)
      chk($sformatf("rr2_gap%0d", j), 64'(obs_cyc[0][j+1] - obs_cyc[0][j]),
          (j % 2 == 1) ? 64'd2 : 64'd1);

    // burst limit 3: inputs 1 and 2 alternate in bursts of at most 3
    do_reset(1);
    push(1, 1, 10); push(1, 2, 10);
    drain(200);
    exp_seq.delete();
    r[1] = 10; r[2] = 10; cur = 1;
    while (r[1] + r[2] > 0) begin
      if (r[cur] == 0) cur = 3 - cur;
      for (int j = 0; j < 3 && r[cur] > 0; j++) begin exp_seq.push_back(cur); r[cur]--; end
      cur = 3 - cur;
    end
    cmp_seq("burst3", 1, exp_seq);

    // sink not-ready for 5 cycles mid-burst
    do_reset(1);
    push(0, 0, 6); push(0, 1, 3);
    repeat (3) step();
    full_req[0] = 1'b0;
    wcnt = 0;
    repeat (5) begin step(); if (wr_obs[0]) wcnt++; end
    chk("stall_trailing_writes", 64'(wcnt), 64'd1);
    full_req[0] = 1'b1;
    drain(100);
    exp_seq = '{0, 0, 0, 1, 1, 1, 0, 0, 0};
    cmp_seq("stall", 0, exp_seq);

    // three inputs: pointer at 2 wraps to input 0
    do_reset(1);
    push(2, 1, 1);
    repeat (4) step();
    push(2, 0, 1);
    drain(50);
    exp_seq = '{1, 0};
    cmp_seq("wrap3", 2, exp_seq);

    // burst 1: strict word-level round robin
    do_reset(1);
    for (int i = 0; i < 3; i++) push(2, i, 2);
    drain(100);
    exp_seq = '{0, 1, 2, 0, 1, 2};
    cmp_seq("mb1", 2, exp_seq);
    for (int j = 0; j + 1 < obs_cyc[2].size() && j < 5; j++)
      chk($sformatf("mb1_gap%0d", j), 64'(obs_cyc[2][j+1] - obs_cyc[2][j]), 64'd2);

    // source tag on input 3
    do_reset(1);
    fifo[0][3].push_back(32'hDEADBEEF);
    drain(50);
`ifdef STREAM_RR_ARBITER_TAG_EN
    tag_exp = {2'd3, 32'hDEADBEEF};
`else
    tag_exp = 32'hDEADBEEF;
`endif
    chk("tag_word", 64'(din_obs[0]), 64'(tag_exp));

    // reset in the middle of a burst; next grant starts from input 0
    do_reset(1);
    push(0, 2, 6);
    repeat (3) step();
    do_reset(1);
    push(0, 0, 1);
    drain(100);
    chk("post_reset_first_src", 64'((obs_src[0].size() > 0) ? obs_src[0][0] : -1), 64'd0);

    // randomized traffic, stalls, dry inputs and occasional resets
    for (int c = 0; c < 3000; c++) begin
      rst_req = ($urandom_range(299) == 0);
      for (int u = 0; u < NU; u++) begin
        full_req[u] = ($urandom_range(4) != 0);
        for (int i = 0; i < nin[u]; i++) begin
          gate[u][i] = ($urandom_range(7) != 0);
          if ($urandom_range(3) == 0 && fifo[u][i].size() < 6) push(u, i, 1);
        end
      end
      step();
    end
    rst_req = 1'b0;
    drain(500);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
